// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding, parameter
// legality and index sizing.
package seq_chunk_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    // A lone chunk still needs a 1-bit index so the register exists.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational W-bit ripple slice; also exposes the carry into its top bit
// so the caller can form signed overflow on the final slice.
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Chunk-serial add/subtract: one CHUNK-bit slice per clock, carry held in a
// register between cycles, result published only on completion.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t state, state_nx;

    logic [IW-1:0]                 idx;
    logic                          carry;
    logic [NCHUNK-1:0][CHUNK-1:0]  a_q, b_q, acc, acc_nx;
    logic [CHUNK-1:0]              s;
    logic                          co, c_msb;
    logic                          last;

    assign last = (idx == LAST_IDX);

    chunk_adder #(.W(CHUNK)) u_slice (
        .x     (a_q[idx]),
        .y     (b_q[idx]),
        .ci    (carry),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    // Accumulator with the current slice merged, so the last chunk can be
    // published in the same edge that computes it.
    always_comb begin
        acc_nx      = acc;
        acc_nx[idx] = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nx;
                    carry <= co;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        sum  <= acc_nx;
                        cout <= co;
                        ovf  <= c_msb ^ co;
                        done <= 1'b1;
                        idx  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for three adder configurations (32/8, 8/8, 8/1) against
// an integer-arithmetic reference model.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start  [3];
    logic        cin_i  [3];
    logic        sub_i  [3];
    logic [31:0] a_i    [3];
    logic [31:0] b_i    [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        cout_o [3];
    logic        ovf_o  [3];
    logic [31:0] sum_o  [3];
    logic [31:0] s0;
    logic [7:0]  s1, s2;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a_i[0]), .b(b_i[0]),
        .cin(cin_i[0]), .sub(sub_i[0]), .busy(busy_o[0]), .sum(s0),
        .cout(cout_o[0]), .ovf(ovf_o[0]), .done(done_o[0]));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a_i[1][7:0]), .b(b_i[1][7:0]),
        .cin(cin_i[1]), .sub(sub_i[1]), .busy(busy_o[1]), .sum(s1),
        .cout(cout_o[1]), .ovf(ovf_o[1]), .done(done_o[1]));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a_i[2][7:0]), .b(b_i[2][7:0]),
        .cin(cin_i[2]), .sub(sub_i[2]), .busy(busy_o[2]), .sum(s2),
        .cout(cout_o[2]), .ovf(ovf_o[2]), .done(done_o[2]));

    assign sum_o[0] = s0;
    assign sum_o[1] = {24'd0, s1};
    assign sum_o[2] = {24'd0, s2};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        q [3][$];
    int          wid [3] = '{32, 8, 8};
    int          nch [3] = '{4, 1, 8};
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] last_sum  [3];
    logic        last_cout [3];
    logic        last_ovf  [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH-bit unsigned/signed values.
    function automatic exp_t model(input int k, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sb, input int acc);
        exp_t   e;
        longint m, ua, ub, sa, sbs, cv, r, rs;
        m   = longint'(1) << wid[k];
        ua  = longint'(av) & (m - 1);
        ub  = longint'(bv) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbs = (ub >= m / 2) ? ub - m : ub;
        cv  = ci ? 1 : 0;
        r   = sb ? ua - ub - cv : ua + ub + cv;
        rs  = sb ? sa - sbs - cv : sa + sbs + cv;
        e.sum  = 32'(r & (m - 1));
        e.cout = sb ? (r >= 0) : (r >= m);
        e.ovf  = (rs < -(m / 2)) || (rs >= m / 2);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: busy, completion results, latency, and output hold between completions.
    always @(negedge clk) begin
        exp_t e;
        logic eb;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                eb = (q[k].size() > 0) && (q[k][0].acc <= cyc) && !done_o[k];
                chk("busy", k, 32'(busy_o[k]), 32'(eb));
                if (done_o[k]) begin
                    if (q[k].size() == 0) begin
                        chk("spurious_done", k, 32'(done_o[k]), 32'd0);
                    end else begin
                        e = q[k].pop_front();
                        chk("sum", k, sum_o[k], e.sum);
                        chk("cout", k, 32'(cout_o[k]), 32'(e.cout));
                        chk("ovf", k, 32'(ovf_o[k]), 32'(e.ovf));
                        chk("latency", k, 32'(cyc - e.acc), 32'(nch[k]));
                        last_sum[k]  = e.sum;
                        last_cout[k] = e.cout;
                        last_ovf[k]  = e.ovf;
                    end
                end else begin
                    chk("sum_hold", k, sum_o[k], last_sum[k]);
                    chk("cout_hold", k, 32'(cout_o[k]), 32'(last_cout[k]));
                    chk("ovf_hold", k, 32'(ovf_o[k]), 32'(last_ovf[k]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start for a cycle; the model entry is queued only if the DUT
    // is idle and will therefore accept it at the coming edge.
    task automatic put(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb);
        a_i[k] = av; b_i[k] = bv; cin_i[k] = ci; sub_i[k] = sb; start[k] = 1'b1;
        if (!busy_o[k]) q[k].push_back(model(k, av, bv, ci, sb, cyc + 1));
        step();
        start[k] = 1'b0;
        a_i[k] = $urandom; b_i[k] = $urandom;
        cin_i[k] = 1'($urandom_range(0, 1)); sub_i[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int k);
        int t = 0;
        while (!done_o[k] && t < 300) begin step(); t++; end
        if (!done_o[k]) chk("done_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while ((busy_o[k] || q[k].size() != 0) && t < 300) begin step(); t++; end
        if (busy_o[k] || q[k].size() != 0) chk("idle_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            last_sum[k] = '0; last_cout[k] = 1'b0; last_ovf[k] = 1'b0;
        end
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0080;
            3:       return 32'h7FFF_FF7F;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; cin_i[k] = 1'b0; sub_i[k] = 1'b0; a_i[k] = '0; b_i[k] = '0;
        end
        do_reset(3);
        step();

        // Directed cases
        put(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_idle(0);
        put(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_idle(0);
        put(0, 32'd5, 32'd7, 1'b0, 1'b1);
        wait_idle(0);
        put(1, 32'h80, 32'h80, 1'b1, 1'b0);
        wait_idle(1);
        put(2, 32'h55, 32'hAB, 1'b0, 1'b0);
        wait_idle(2);

        // Start while busy is ignored; start in the done cycle is taken
        put(0, 32'd10, 32'd3, 1'b0, 1'b1);
        put(0, 32'd1, 32'd1, 1'b0, 1'b0);
        wait_done(0);
        put(0, 32'd1, 32'd1, 1'b0, 1'b0);
        wait_idle(0);

        // Reset mid-operation aborts with no done pulse
        put(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        step();
        do_reset(1);
        repeat (6) step();
        put(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
        wait_idle(0);

        // Random sweep with random gaps, including starts issued while busy
        for (int k = 0; k < 3; k++) begin
            repeat (60) begin
                repeat ($urandom_range(0, 3)) step();
                put(k, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            wait_idle(k);
        end

        // start held high continuously on every configuration
        repeat (40) begin
            for (int k = 0; k < 3; k++) begin
                a_i[k] = $urandom; b_i[k] = $urandom;
                cin_i[k] = 1'($urandom_range(0, 1)); sub_i[k] = 1'($urandom_range(0, 1));
                start[k] = 1'b1;
                if (!busy_o[k]) q[k].push_back(model(k, a_i[k], b_i[k], cin_i[k], sub_i[k], cyc + 1));
            end
            step();
        end
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        for (int k = 0; k < 3; k++) wait_idle(k);

        repeat (4) step();
        for (int k = 0; k < 3; k++) chk("drain", k, 32'(q[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
